dircc_link_fifo: RTL and testbench

DIRCC_LINK_FIFO -- requirements
Module: dircc_link_fifo

---
 rtl/dircc_pkg.sv | 21 ++
 rtl/dircc_fifo_ram.sv | 25 ++
 rtl/dircc_link_fifo.sv | 138 +++++++++++++
 tb/tb_dircc_link_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_pkg.sv
// Shared widths, stored-beat layout and framing-checker state encoding for the
// DIRCC inter-node link FIFO.
package dircc_pkg;

    localparam int DIRCC_DATA_W  = 32;
    localparam int DIRCC_EMPTY_W = 2;

    // Field order matches the packed word held in each FIFO entry.
    typedef struct packed {
        logic                     sop;
        logic                     eop;
        logic [DIRCC_EMPTY_W-1:0] empty;
        logic [DIRCC_DATA_W-1:0]  data;
    } dircc_beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } dircc_pkt_state_e;

endpackage

// File: rtl/dircc_fifo_ram.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port so the FIFO head is visible in the same cycle.
module dircc_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dircc_link_fifo.sv
// First-word-fall-through Avalon-ST link FIFO between two DIRCC nodes.
// Define DIRCC_LINK_FIFO_PKT_CHECK_EN to compile in the sop/eop framing checker.
module dircc_link_fifo
    import dircc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = DIRCC_DATA_W,
    parameter int EMPTY_W = DIRCC_EMPTY_W
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic [EMPTY_W-1:0]       in_empty,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [EMPTY_W-1:0]       out_empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              error_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int BEAT_W = DATA_W + EMPTY_W + 2;

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       fill_reg;
    logic [AW:0]       fill_next;
    logic              in_ready_reg;
    logic              accept;
    logic              store_en;
    logic              rd_en;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;

    // The ready register comes out of reset set, but is masked while reset is
    // held so the upstream node sees backpressure until the FIFO is live.
    assign in_ready   = in_ready_reg && !reset_reset;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (fill_reg != '0);
    assign rd_en      = out_valid && out_ready;
    assign fill_level = fill_reg;
    assign fill_next  = fill_reg + (AW+1)'(store_en) - (AW+1)'(rd_en);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            if (store_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            fill_reg     <= fill_next;
            in_ready_reg <= (fill_next != (AW+1)'(DEPTH));
        end
    end

    assign wr_beat = {in_startofpacket, in_endofpacket, in_empty, in_data};
    assign {out_startofpacket, out_endofpacket, out_empty, out_data} = rd_beat;

    dircc_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_ram (
        .clk     (clk_clk),
        .wr_en   (store_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_beat)
    );

`ifdef DIRCC_LINK_FIFO_PKT_CHECK_EN
    dircc_pkt_state_e state_reg;
    dircc_pkt_state_e state_next;
    logic             frame_err;
    logic [15:0]      err_cnt_reg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg   <= IDLE;
            err_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (frame_err && err_cnt_reg != 16'hFFFF) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    // Orphan beats outside a packet are consumed but dropped; a repeated sop
    // inside a packet is kept (the receiver resynchronises on it) but counted.
    always_comb begin
        state_next = state_reg;
        store_en   = 1'b0;
        frame_err  = 1'b0;
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (in_startofpacket) begin
                        store_en = 1'b1;
                        if (!in_endofpacket) begin
                            state_next = IN_PKT;
                        end
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                IN_PKT: begin
                    store_en  = 1'b1;
                    frame_err = in_startofpacket;
                    if (in_endofpacket) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign error_count = err_cnt_reg;
`else
    assign store_en    = accept;
    assign error_count = '0;
`endif

endmodule

// File: tb/tb_dircc_link_fifo.sv
// Scoreboard bench for dircc_link_fifo: accepted beats are queued as expected
// output and popped when the DUT hands a beat downstream.
module tb_dircc_link_fifo;
    import dircc_pkg::*;

    localparam int DEPTH = 8;
`ifdef DIRCC_LINK_FIFO_PKT_CHECK_EN
    localparam int EXP_PKT_BEATS = 3;
    localparam int EXP_PKT_ERRS  = 2;
`else
    localparam int EXP_PKT_BEATS = 4;
    localparam int EXP_PKT_ERRS  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_empty;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_empty;
    logic [3:0]  fill_level;
    logic [15:0] error_count;

    dircc_link_fifo #(.DEPTH(DEPTH)) dut (
        .clk_clk           (clk),
        .reset_reset       (reset_reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .fill_level        (fill_level),
        .error_count       (error_count)
    );

    always #5 clk = ~clk;

    dircc_beat_t exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_popped = 0;
    int          exp_err  = 0;
    logic        m_in_pkt = 1'b0;

    logic        acc;
    logic        rdd;
    logic        obs_out_valid;
    logic        obs_in_ready;
    logic [3:0]  obs_fill;
    logic [15:0] obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference framing behaviour applied to every beat the DUT accepts.
    task automatic model_accept(input logic s, input logic e, input logic [1:0] emp, input logic [31:0] d);
        dircc_beat_t b;
        b.sop = s; b.eop = e; b.empty = emp; b.data = d;
`ifdef DIRCC_LINK_FIFO_PKT_CHECK_EN
        if (!m_in_pkt) begin
            if (s) begin
                exp_q.push_back(b);
                m_in_pkt = !e;
            end else begin
                exp_err++;
            end
        end else begin
            exp_q.push_back(b);
            if (s) exp_err++;
            if (e) m_in_pkt = 1'b0;
        end
`else
        exp_q.push_back(b);
`endif
    endtask

    // One clock: drive at the falling edge, observe, and account for the
    // handshakes that the next rising edge will perform.
    task automatic step(input logic v, input logic s, input logic e, input logic [31:0] d, input logic rdy);
        dircc_beat_t got;
        dircc_beat_t exp;
        @(negedge clk);
        in_valid = v; in_startofpacket = s; in_endofpacket = e;
        in_data = d; in_empty = d[1:0]; out_ready = rdy;
        #1;
        obs_out_valid = out_valid;
        obs_in_ready  = in_ready;
        obs_fill      = fill_level;
        obs_err       = error_count;
        acc = v && in_ready;
        rdd = out_valid && rdy;
        if (rdd) begin
            got = {out_startofpacket, out_endofpacket, out_empty, out_data};
            $display("beat out sop=%0b eop=%0b empty=%0d data=%08h", got.sop, got.eop, got.empty, got.data);
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(got), 64'h0);
            end else begin
                exp = exp_q.pop_front();
                check("beat", 64'(got), 64'(exp));
            end
            n_popped++;
        end
        if (acc) model_accept(s, e, d[1:0], d);
    endtask

    task automatic send(input logic s, input logic e, input logic [31:0] d, input logic rdy);
        int tries = 0;
        do begin
            step(1'b1, s, e, d, rdy);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) check("send_timeout", 64'(acc), 64'h1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_valid", 64'(obs_out_valid), 64'h0);
        check("drain_fill", 64'(obs_fill), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_fill", 64'(fill_level), 64'h0);
        check("rst_err", 64'(error_count), 64'h0);
        @(negedge clk);
        reset_reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'h1);
        exp_q.delete();
        m_in_pkt = 1'b0;
        exp_err  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        int popped0;
        reset_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
        do_reset();

        // Three-beat packet, first beat visible one cycle after its write.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("empty_out_valid", 64'(obs_out_valid), 64'h0);
        send(1'b1, 1'b0, 32'h11, 1'b1);
        check("pre_write_valid", 64'(obs_out_valid), 64'h0);
        send(1'b0, 1'b0, 32'h22, 1'b1);
        check("latency1_valid", 64'(obs_out_valid), 64'h1);
        send(1'b0, 1'b1, 32'h33, 1'b1);
        drain();

        // Fill to DEPTH with the sink stalled, then release it.
        for (int i = 0; i < DEPTH; i++) send(i == 0, 1'b0, 32'h100 + 32'(i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("full_in_ready", 64'(obs_in_ready), 64'h0);
        check("full_fill", 64'(obs_fill), 64'(DEPTH));
        check("full_out_valid", 64'(obs_out_valid), 64'h1);
        for (int i = DEPTH; i < 10; i++) send(1'b0, i == 9, 32'h100 + 32'(i), 1'b1);
        drain();

        // Full FIFO with both sides active: one beat per cycle, level steady.
        for (int i = 0; i < DEPTH; i++) send(i == 0, 1'b0, 32'h200 + 32'(i), 1'b0);
        k = DEPTH;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'h200 + 32'(k), 1'b1);
            if (acc) k++;
            if (c == 0) begin
                check("stream_first_in_ready", 64'(obs_in_ready), 64'h0);
            end else begin
                check("steady_xfer", 64'(acc && rdd), 64'h1);
                check("steady_fill", 64'(obs_fill), 64'(DEPTH - 1));
            end
        end
        send(1'b0, 1'b1, 32'h2FF, 1'b1);
        drain();

        // Reset with half a packet stored; nothing stale may follow.
        send(1'b1, 1'b0, 32'hA1, 1'b0);
        send(1'b0, 1'b0, 32'hA2, 1'b0);
        do_reset();
        send(1'b1, 1'b0, 32'hB1, 1'b1);
        send(1'b0, 1'b1, 32'hB2, 1'b1);
        drain();

        // Framing: orphan beat, then sop, sop, eop.
        popped0 = n_popped;
        send(1'b0, 1'b0, 32'hDEAD, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("orphan_err", 64'(obs_err), 64'(exp_err));
        send(1'b1, 1'b0, 32'h1, 1'b1);
        send(1'b1, 1'b0, 32'h2, 1'b1);
        send(1'b0, 1'b1, 32'h3, 1'b1);
        drain();
        check("pkt_beats", 64'(n_popped - popped0), 64'(EXP_PKT_BEATS));
        check("pkt_err_model", 64'(obs_err), 64'(exp_err));
        check("pkt_err", 64'(obs_err), 64'(EXP_PKT_ERRS));

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
